// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the dual-port on-chip RAM: clear-sequencer states,
// legal read-latency values and the byte-enable width helper.
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    localparam int LAT_UNREG = 1;
    localparam int LAT_REG   = 2;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_ram_dp_core.sv
// True-dual-port byte-enabled array, synchronous read (1 cycle), old data on mixed-port
// read-during-write. No backpressure; callers guarantee the two ports never write one word together.
module onchip_ram_dp_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000,
    parameter int ADDR_W = 15,
    parameter int BE_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_a_we,
    input  logic              i_a_re,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [BE_W-1:0]   i_a_be,
    input  logic [DATA_W-1:0] i_a_wdat,
    output logic [DATA_W-1:0] o_a_rdat,
    input  logic              i_b_we,
    input  logic              i_b_re,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [BE_W-1:0]   i_b_be,
    input  logic [DATA_W-1:0] i_b_wdat,
    output logic [DATA_W-1:0] o_b_rdat
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_q;
    logic [DATA_W-1:0] r_b_q;
    logic [IDX_W-1:0]  w_a_idx;
    logic [IDX_W-1:0]  w_b_idx;

    // Upper address bits only matter for the range check done in the top.
    assign w_a_idx = i_a_addr[IDX_W-1:0];
    assign w_b_idx = i_b_addr[IDX_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_a_re) r_a_q <= r_mem[w_a_idx];
        if (i_b_re) r_b_q <= r_mem[w_b_idx];
        for (int b = 0; b < BE_W; b++) begin
            if (i_a_we && i_a_be[b]) r_mem[w_a_idx][b*8 +: 8] <= i_a_wdat[b*8 +: 8];
            if (i_b_we && i_b_be[b]) r_mem[w_b_idx][b*8 +: 8] <= i_b_wdat[b*8 +: 8];
        end
    end

    assign o_a_rdat = r_a_q;
    assign o_b_rdat = r_b_q;

endmodule

// File: rtl/onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM; reads return after READ_LATENCY (1 or 2) cycles, fully pipelined.
// waitrequest is combinational: both ports stall during the post-reset clear, s2 stalls on a write/write collision.
module onchip_ram_dp
    import onchip_ram_pkg::*;
#(
    parameter int  DATA_W         = 32,
    parameter int  DEPTH          = 32000,
    parameter int  ADDR_W         = $clog2(DEPTH),
    parameter int  READ_LATENCY   = LAT_UNREG,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int BE_W           = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_chipselect,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic              s1_waitrequest,
    input  logic [ADDR_W-1:0] s2_address,
    input  logic [BE_W-1:0]   s2_byteenable,
    input  logic              s2_chipselect,
    input  logic              s2_read,
    input  logic              s2_write,
    input  logic [DATA_W-1:0] s2_writedata,
    output logic [DATA_W-1:0] s2_readdata,
    output logic              s2_readdatavalid,
    output logic              s2_waitrequest
);

    clr_state_t        r_clr_state;
    logic [ADDR_W-1:0] r_clr_ctr;
    logic              w_clr_busy, w_clr_wr;
    logic              w_s1_inr, w_s2_inr, w_coll;
    logic              w_s1_acc, w_s2_acc, w_s1_wr, w_s2_wr, w_s1_rd, w_s2_rd;
    logic              w_a_we;
    logic [ADDR_W-1:0] w_a_addr;
    logic [BE_W-1:0]   w_a_be;
    logic [DATA_W-1:0] w_a_wdat;
    logic [DATA_W-1:0] w_q1, w_q2, w_d1_s1, w_d1_s2;
    logic [1:0]        r_vld1, r_inr1;

    generate
        if (CLEAR_ON_RESET != 0) begin : g_clr
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_clr_state <= CLR_IDLE;
                    r_clr_ctr   <= '0;
                end else begin
                    case (r_clr_state)
                        CLR_IDLE: begin
                            r_clr_state <= CLR_RUN;
                            r_clr_ctr   <= '0;
                        end
                        CLR_RUN: begin
                            if (r_clr_ctr == ADDR_W'(DEPTH - 1)) r_clr_state <= CLR_DONE;
                            else                                 r_clr_ctr   <= r_clr_ctr + ADDR_W'(1);
                        end
                        default: r_clr_state <= CLR_DONE;
                    endcase
                end
            end
        end else begin : g_noclr
            assign r_clr_state = CLR_DONE;
            assign r_clr_ctr   = '0;
        end
    endgenerate

    assign w_clr_busy = (r_clr_state != CLR_DONE);
    assign w_clr_wr   = (r_clr_state == CLR_RUN);

    assign w_s1_inr = (32'(s1_address) < DEPTH);
    assign w_s2_inr = (32'(s2_address) < DEPTH);

    // Only an in-range same-word write pair collides; out-of-range writes are dropped anyway.
    assign w_coll = s1_chipselect & s1_write & s2_chipselect & s2_write
                  & (s1_address == s2_address) & w_s1_inr;

    assign s1_waitrequest = w_clr_busy;
    assign s2_waitrequest = w_clr_busy | w_coll;

    assign w_s1_acc = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
    assign w_s2_acc = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
    assign w_s1_wr  = w_s1_acc & s1_write;
    assign w_s2_wr  = w_s2_acc & s2_write;
    assign w_s1_rd  = w_s1_acc & s1_read & ~s1_write;
    assign w_s2_rd  = w_s2_acc & s2_read & ~s2_write;

    assign w_a_we   = w_clr_wr | (w_s1_wr & w_s1_inr);
    assign w_a_addr = w_clr_wr ? r_clr_ctr : s1_address;
    assign w_a_be   = w_clr_wr ? '1 : s1_byteenable;
    assign w_a_wdat = w_clr_wr ? '0 : s1_writedata;

    onchip_ram_dp_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_core (
        .i_clk    (clk),
        .i_a_we   (w_a_we),
        .i_a_re   (w_s1_rd & w_s1_inr),
        .i_a_addr (w_a_addr),
        .i_a_be   (w_a_be),
        .i_a_wdat (w_a_wdat),
        .o_a_rdat (w_q1),
        .i_b_we   (w_s2_wr & w_s2_inr),
        .i_b_re   (w_s2_rd & w_s2_inr),
        .i_b_addr (s2_address),
        .i_b_be   (s2_byteenable),
        .i_b_wdat (s2_writedata),
        .o_b_rdat (w_q2)
    );

    // r_inr1 only moves on a read, so a zero from an out-of-range read is held like real data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld1 <= '0;
            r_inr1 <= '0;
        end else begin
            r_vld1 <= {w_s2_rd, w_s1_rd};
            if (w_s1_rd) r_inr1[0] <= w_s1_inr;
            if (w_s2_rd) r_inr1[1] <= w_s2_inr;
        end
    end

    assign w_d1_s1 = r_inr1[0] ? w_q1 : '0;
    assign w_d1_s2 = r_inr1[1] ? w_q2 : '0;

    generate
        if (READ_LATENCY == LAT_REG) begin : g_lat2
            logic [1:0]        r_vld2;
            logic [DATA_W-1:0] r_dat2_s1, r_dat2_s2;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_vld2    <= '0;
                    r_dat2_s1 <= '0;
                    r_dat2_s2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1[0]) r_dat2_s1 <= w_d1_s1;
                    if (r_vld1[1]) r_dat2_s2 <= w_d1_s2;
                end
            end
            assign s1_readdatavalid = r_vld2[0];
            assign s2_readdatavalid = r_vld2[1];
            assign s1_readdata      = r_dat2_s1;
            assign s2_readdata      = r_dat2_s2;
        end else begin : g_lat1
            assign s1_readdatavalid = r_vld1[0];
            assign s2_readdatavalid = r_vld1[1];
            assign s1_readdata      = w_d1_s1;
            assign s2_readdata      = w_d1_s2;
        end
    endgenerate

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Bench for onchip_ram_dp (DEPTH=16, 5-bit address so out-of-range words are reachable, READ_LATENCY=2).
// A word-array model with per-port expected-read queues is checked every cycle.
module tb_onchip_ram_dp;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] s1_address, s2_address;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic          s1_chipselect, s2_chipselect, s1_read, s2_read, s1_write, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

    always #5 clk = ~clk;

    onchip_ram_dp #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
        .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
        .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
    );

    typedef struct packed {
        int          due;
        logic [31:0] dat;
    } rd_t;

    rd_t         q [2][$];
    logic [31:0] mem [DEPTH];
    logic [31:0] last [2];
    logic        got_v [2];
    logic [31:0] got_d [2];
    int          k;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [AW-1:0] a);
        if (int'(a) < DEPTH) return mem[a[3:0]];
        return 32'd0;
    endfunction

    function automatic void mwrite(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        if (int'(a) < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic void mreset();
        k = 0;
        q[0].delete();
        q[1].delete();
        last[0] = 32'd0;
        last[1] = 32'd0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    endfunction

    function automatic logic coll_now();
        return s1_chipselect && s1_write && s2_chipselect && s2_write
            && (s1_address == s2_address) && (int'(s1_address) < DEPTH);
    endfunction

    // One bus cycle: check outputs at the negedge, then advance the model on the posedge.
    task automatic step();
        logic ev, busy, coll;
        rd_t  e;
        @(negedge clk);
        busy = !reset_n || (k <= DEPTH);
        chk("s1_waitrequest", 32'(s1_waitrequest), 32'(busy));
        chk("s2_waitrequest", 32'(s2_waitrequest), 32'(busy || coll_now()));
        got_v[0] = s1_readdatavalid; got_v[1] = s2_readdatavalid;
        got_d[0] = s1_readdata;      got_d[1] = s2_readdata;
        for (int p = 0; p < 2; p++) begin
            while (q[p].size() > 0 && q[p][0].due < k) void'(q[p].pop_front());
            ev = (q[p].size() > 0) && (q[p][0].due == k);
            chk($sformatf("s%0d_readdatavalid", p + 1), 32'(got_v[p]), 32'(ev));
            if (ev) begin
                last[p] = q[p][0].dat;
                void'(q[p].pop_front());
            end
            chk($sformatf("s%0d_readdata", p + 1), got_d[p], last[p]);
        end
        @(posedge clk);
        if (reset_n) begin
            busy = (k <= DEPTH);
            coll = coll_now();
            if (!busy && s1_chipselect && s1_read && !s1_write) begin
                e.due = k + LAT; e.dat = mread(s1_address); q[0].push_back(e);
            end
            if (!busy && !coll && s2_chipselect && s2_read && !s2_write) begin
                e.due = k + LAT; e.dat = mread(s2_address); q[1].push_back(e);
            end
            if (!busy && s1_chipselect && s1_write) mwrite(s1_address, s1_byteenable, s1_writedata);
            if (!busy && !coll && s2_chipselect && s2_write) mwrite(s2_address, s2_byteenable, s2_writedata);
            k++;
        end
        #1;
    endtask

    task automatic cmd1(input logic rd, input logic wr, input int a, input logic [3:0] be, input logic [31:0] d);
        s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
        s1_address = AW'(a); s1_byteenable = be; s1_writedata = d;
    endtask

    task automatic cmd2(input logic rd, input logic wr, input int a, input logic [3:0] be, input logic [31:0] d);
        s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
        s2_address = AW'(a); s2_byteenable = be; s2_writedata = d;
    endtask

    task automatic idle(input int n);
        cmd1(1'b0, 1'b0, 0, 4'h0, 32'd0);
        cmd2(1'b0, 1'b0, 0, 4'h0, 32'd0);
        repeat (n) step();
    endtask

    initial begin
        mreset();
        idle(3);
        reset_n = 1'b1;
        idle(DEPTH + 2);

        for (int a = 0; a < DEPTH; a++) begin
            cmd2(1'b1, 1'b0, a, 4'h0, 32'd0);
            step();
        end
        idle(3);

        cmd1(1'b0, 1'b1, 5, 4'hF, 32'hDEADBEEF); step();
        cmd1(1'b1, 1'b0, 5, 4'h0, 32'd0);        step();
        cmd1(1'b1, 1'b0, 6, 4'h0, 32'd0);        step();
        cmd1(1'b1, 1'b0, 5, 4'h0, 32'd0);        step();
        idle(3);

        cmd1(1'b0, 1'b1, 9, 4'b0101, 32'h11223344); step();
        idle(0); cmd2(1'b1, 1'b0, 9, 4'h0, 32'd0);  step();
        idle(3);

        cmd1(1'b0, 1'b1, 3, 4'hF, 32'hAAAA0000);
        cmd2(1'b0, 1'b1, 3, 4'hF, 32'h0000BBBB); step();
        cmd1(1'b0, 1'b0, 0, 4'h0, 32'd0);        step();
        idle(0); cmd1(1'b1, 1'b0, 3, 4'h0, 32'd0); step();
        idle(3);

        cmd1(1'b0, 1'b1, 7, 4'hF, 32'h9); step();
        idle(1);
        cmd1(1'b0, 1'b1, 7, 4'hF, 32'h5);
        cmd2(1'b1, 1'b0, 7, 4'h0, 32'd0); step();
        idle(0); cmd2(1'b1, 1'b0, 7, 4'h0, 32'd0); step();
        idle(3);

        cmd1(1'b1, 1'b0, DEPTH + 1, 4'h0, 32'd0);       step();
        cmd2(1'b0, 1'b1, 20, 4'hF, 32'hFFFFFFFF);       step();
        idle(0); cmd2(1'b1, 1'b0, 20, 4'h0, 32'd0);     step();
        cmd1(1'b0, 1'b1, 5, 4'h0, 32'h12345678);        step();
        cmd1(1'b1, 1'b1, 6, 4'hF, 32'h66);              step();
        cmd1(1'b1, 1'b0, 5, 4'h0, 32'd0);               step();
        cmd1(1'b1, 1'b0, 6, 4'h0, 32'd0);               step();
        cmd1(1'b0, 1'b1, 1, 4'hF, 32'h0101);
        cmd2(1'b0, 1'b1, 2, 4'hF, 32'h0202);            step();
        cmd1(1'b1, 1'b0, 2, 4'h0, 32'd0);
        cmd2(1'b1, 1'b0, 1, 4'h0, 32'd0);               step();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            cmd1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19),
                 4'($urandom), $urandom);
            s1_chipselect = ($urandom_range(0, 7) != 0);
            cmd2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 19),
                 4'($urandom), $urandom);
            s2_chipselect = ($urandom_range(0, 7) != 0);
            step();
        end
        idle(3);

        cmd1(1'b1, 1'b0, 5, 4'h0, 32'd0); step();
        reset_n = 1'b0;
        mreset();
        idle(4);
        reset_n = 1'b1;
        idle(DEPTH + 3);
        cmd2(1'b1, 1'b0, 5, 4'h0, 32'd0); step();
        idle(4);

        chk("drain", 32'(q[0].size() + q[1].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
